// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and sizing helpers.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;

  // Clocks per oversample tick, integer floor.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received word and status flags out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  busy;

  // Line driver and word consumer.
  modport master (
    output rx_data,
    input  data_out, valid, parity_err, frame_err, busy
  );

  // The receiver itself.
  modport slave (
    input  rx_data,
    output data_out, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, restartable.
module uart_rx_tick
  import uart_rx_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider; clear realigns the phase to the detected start edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, oversampled framing FSM, LSB-first shifter, parity/stop checks.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_BIT = 1,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic    clk,
  input  logic    rst,
  uart_rx_if.slave bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = cnt_w(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic                  sync1, rx_s;
  rx_state_t             state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bad, frm_bad, stop_idx;
  logic                  tick, clr, full_sample, last_stop;

  assign clr         = (state == ST_IDLE) && !rx_s;
  assign full_sample = tick && (tick_cnt == FULL_LAST);
  assign last_stop   = (STOP_BITS < 2) || stop_idx;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clr),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_data;
      rx_s  <= sync1;
    end
  end

  // Frame FSM with registered outputs; errored frames are still delivered with flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_bad        <= 1'b0;
      frm_bad        <= 1'b0;
      stop_idx       <= 1'b0;
      bus.data_out   <= '0;
      bus.valid      <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            busy_set();
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end else begin
                state    <= ST_IDLE;
                bus.busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) tick_cnt <= tick_cnt + TW'(1);
          if (full_sample) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              state    <= (PARITY_BIT != 0) ? ST_PARITY : ST_STOP;
              par_bad  <= 1'b0;
              frm_bad  <= 1'b0;
              stop_idx <= 1'b0;
            end
          end
        end
        ST_PARITY: begin
          if (tick) tick_cnt <= tick_cnt + TW'(1);
          if (full_sample) begin
            tick_cnt <= '0;
            par_bad  <= (^shreg) ^ rx_s;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) tick_cnt <= tick_cnt + TW'(1);
          if (full_sample) begin
            tick_cnt <= '0;
            if (last_stop) begin
              bus.data_out   <= shreg;
              bus.parity_err <= par_bad;
              bus.frame_err  <= frm_bad | !rx_s;
              bus.valid      <= 1'b1;
              state          <= rx_s ? ST_IDLE : ST_BREAK;
              bus.busy       <= !rx_s;
            end else begin
              stop_idx <= 1'b1;
              frm_bad  <= frm_bad | !rx_s;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  task automatic busy_set();
    bus.busy <= 1'b1;
  endtask
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=10 (160 clocks per bit).
module tb_uart_rx;
  localparam int BIT = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(
    .DATA_WIDTH(8),
    .PARITY_BIT(1),
    .STOP_BITS (1),
    .BAUD_RATE (9600),
    .CLK_FREQ  (1_536_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Valid-pulse monitor: counts pulses, widest run, and captures delivered frames.
  int         vcnt = 0;
  int         vrun = 0;
  int         vmax = 0;
  logic [7:0] cap_d[$];
  logic       cap_err[$];

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vrun = vrun + 1;
      if (vrun > vmax) vmax = vrun;
      if (vrun == 1) begin
        vcnt = vcnt + 1;
        cap_d.push_back(bus.data_out);
        cap_err.push_back(bus.parity_err | bus.frame_err);
      end
    end else begin
      vrun = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold the line at b for n clocks; returns 1 time unit past a rising edge.
  task automatic line(input logic b, input int n);
    bus.rx_data = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    line(par, BIT);
    line(stp, BIT);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(bus.data_out),   32'h0);
    chk({tag, "_valid"}, 32'(bus.valid),      32'h0);
    chk({tag, "_perr"},  32'(bus.parity_err), 32'h0);
    chk({tag, "_ferr"},  32'(bus.frame_err),  32'h0);
    chk({tag, "_busy"},  32'(bus.busy),       32'h0);
  endtask

  initial begin
    int v0;
    int n0;
    bus.rx_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    line(1'b1, 50);

    // 0xA5 has four ones: even parity bit 0
    v0 = vcnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    line(1'b1, 40);
    chk("a5_vcnt", 32'(vcnt), 32'(v0 + 1));
    chk("a5_data", 32'(bus.data_out), 32'hA5);
    chk("a5_perr", 32'(bus.parity_err), 32'h0);
    chk("a5_ferr", 32'(bus.frame_err), 32'h0);
    chk("a5_busy", 32'(bus.busy), 32'h0);
    chk("a5_width", 32'(vmax), 32'h1);

    // 0x01 needs parity 1; send 0
    v0 = vcnt;
    send_frame(8'h01, 1'b0, 1'b1);
    line(1'b1, 40);
    chk("p_vcnt", 32'(vcnt), 32'(v0 + 1));
    chk("p_data", 32'(bus.data_out), 32'h01);
    chk("p_perr", 32'(bus.parity_err), 32'h1);
    chk("p_ferr", 32'(bus.frame_err), 32'h0);

    // 0x5A with stop bit low, then line held low
    v0 = vcnt;
    send_frame(8'h5A, 1'b0, 1'b0);
    line(1'b0, 1000);
    chk("brk_vcnt", 32'(vcnt), 32'(v0 + 1));
    chk("brk_data", 32'(bus.data_out), 32'h5A);
    chk("brk_ferr", 32'(bus.frame_err), 32'h1);
    chk("brk_perr", 32'(bus.parity_err), 32'h0);
    chk("brk_busy_low", 32'(bus.busy), 32'h1);
    line(1'b1, 200);
    chk("brk_busy_rel", 32'(bus.busy), 32'h0);
    chk("brk_no_2nd", 32'(vcnt), 32'(v0 + 1));

    // Glitch: 40 clocks low
    v0 = vcnt;
    line(1'b0, 40);
    chk("gl_busy_hi", 32'(bus.busy), 32'h1);
    line(1'b1, 50);
    chk("gl_busy_lo", 32'(bus.busy), 32'h0);
    line(1'b1, 200);
    chk("gl_no_valid", 32'(vcnt), 32'(v0));
    chk("gl_hold_ferr", 32'(bus.frame_err), 32'h1);

    // Reset after data bit 3 of 0xFF
    v0 = vcnt;
    line(1'b0, BIT);
    line(1'b1, 4 * BIT);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all_zero("mrst");
    line(1'b1, 400);
    chk("mrst_no_valid", 32'(vcnt), 32'(v0));
    send_frame(8'h3C, 1'b0, 1'b1);
    line(1'b1, 40);
    chk("3c_vcnt", 32'(vcnt), 32'(v0 + 1));
    chk("3c_data", 32'(bus.data_out), 32'h3C);
    chk("3c_perr", 32'(bus.parity_err), 32'h0);
    chk("3c_ferr", 32'(bus.frame_err), 32'h0);

    // Back-to-back 0x00 then 0xFF, both even parity 0, no idle gap
    v0 = vcnt;
    n0 = cap_d.size();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    line(1'b1, 40);
    chk("b2b_vcnt", 32'(vcnt), 32'(v0 + 2));
    if (cap_d.size() >= n0 + 2) begin
      chk("b2b_d0", 32'(cap_d[n0]), 32'h00);
      chk("b2b_d1", 32'(cap_d[n0 + 1]), 32'hFF);
      chk("b2b_e0", 32'(cap_err[n0]), 32'h0);
      chk("b2b_e1", 32'(cap_err[n0 + 1]), 32'h0);
    end else begin
      chk("b2b_captured", 32'(cap_d.size()), 32'(n0 + 2));
    end
    chk("valid_width", 32'(vmax), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
